// File: rtl/fifo_push_arbiter.sv
// ============================================================================
// Module   : fifo_push_arbiter
// Brief    : Round-robin arbiter that streams bursts from NUM_REQ producers
//            into a single FIFO write port, gated by the FIFO full flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_push_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy
);

    localparam int               c_IDX_W      = $clog2(NUM_REQ);
    localparam logic [c_IDX_W:0] c_NUM        = (c_IDX_W+1)'(NUM_REQ);
    localparam logic [c_IDX_W:0] c_ONE        = (c_IDX_W+1)'(1);
    localparam logic [7:0]       c_BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   w_owner_nxt;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [7:0]           r_burst_cnt;
    logic [7:0]           w_burst_cnt_nxt;

    logic [c_IDX_W:0]     w_last_inc;
    logic [c_IDX_W-1:0]   w_start;
    logic [c_IDX_W:0]     w_cand;
    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_winner_vld;
    logic                 w_req_own;
    logic [DATA_WIDTH-1:0] w_data_own;
    logic                 w_accept;
    logic                 w_burst_done;

    // Search starts one past the previous owner, wrapping modulo NUM_REQ
    assign w_last_inc = {1'b0, r_last} + c_ONE;
    assign w_start    = (w_last_inc == c_NUM) ? '0 : w_last_inc[c_IDX_W-1:0];

    // Descending scan so the candidate closest to the start position wins
    always_comb begin
        w_cand       = '0;
        w_winner     = '0;
        w_winner_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, w_start} + (c_IDX_W+1)'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            if (req[w_cand[c_IDX_W-1:0]]) begin
                w_winner     = w_cand[c_IDX_W-1:0];
                w_winner_vld = 1'b1;
            end
        end
    end

    // Owner's request bit and data slice; data stays driven even when idle
    always_comb begin
        w_req_own  = 1'b0;
        w_data_own = req_data[DATA_WIDTH-1:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == c_IDX_W'(k)) begin
                w_req_own  = req[k];
                w_data_own = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A word presented during a reset cycle must not be taken
    assign w_accept     = (r_state == ST_SERVE) && w_req_own && !fifo_full && !rst_n;
    assign w_burst_done = w_accept && (r_burst_cnt == c_BURST_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_winner_vld) begin
                    w_state_nxt     = ST_SERVE;
                    w_grant_nxt     = NUM_REQ'(1) << w_winner;
                    w_owner_nxt     = w_winner;
                    w_burst_cnt_nxt = '0;
                end
            end
            ST_SERVE: begin
                if (w_accept) begin
                    w_burst_cnt_nxt = r_burst_cnt + 8'd1;
                end
                if (w_burst_done || !w_req_own) begin
                    w_state_nxt     = ST_IDLE;
                    w_grant_nxt     = '0;
                    w_last_nxt      = r_owner;
                    w_burst_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_last      <= c_IDX_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    assign ack       = w_accept ? r_grant : '0;
    assign grant     = r_grant;
    assign fifo_push = w_accept;
    assign fifo_data = w_data_own;
    assign busy      = (r_state == ST_SERVE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Brief    : Self-checking bench for fifo_push_arbiter (vectors, corner
//            sequences and randomized traffic against a reference model).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_push_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             fifo_full;
    logic             fifo_push;
    logic [DW-1:0]    fifo_data;
    logic             busy;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant     (grant),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 = nobody), previous owner, words taken
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_cnt   = 0;

    logic [NR-1:0] s_ack;
    logic          s_push;
    logic [DW-1:0] s_data;
    logic [NR-1:0] s_grant;
    logic          s_busy;

    logic [DW-1:0] dat [NR];
    int            order [8];
    int            n_ord;
    logic [NR-1:0] prev_grant;

    typedef struct {
        logic [NR-1:0]    q;
        logic [NR*DW-1:0] d;
        logic             f;
        logic [NR-1:0]    e_grant;
        logic             e_push;
        logic [DW-1:0]    e_data;
        logic [NR-1:0]    e_ack;
        logic             e_busy;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic m_accept();
        return (rst_n === 1'b0) && (m_owner >= 0) && req[m_owner] && !fifo_full;
    endfunction

    task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR*DW-1:0] d,
                         input logic f);
        rst_n     = r;
        req       = q;
        req_data  = d;
        fifo_full = f;
    endtask

    task automatic sample();
        @(negedge clk);
        s_ack   = ack;
        s_push  = fifo_push;
        s_data  = fifo_data;
        s_grant = grant;
        s_busy  = busy;
    endtask

    task automatic model_check();
        logic a;
        a = m_accept();
        chk("ack", 32'(s_ack), a ? (32'd1 << m_owner) : 32'd0);
        chk("push", 32'(s_push), 32'(a));
        if (a) chk("data", 32'(s_data), 32'(req_data[m_owner*DW +: DW]));
        chk("grant", 32'(s_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(s_busy), 32'(m_owner >= 0));
    endtask

    // Advance one clock edge and apply the arbitration rules to the model
    task automatic adv();
        logic a;
        bit   found;
        int   idx;
        a = m_accept();
        @(posedge clk);
        if (rst_n) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (!found && req[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_cnt   = 0;
                end
            end
        end else if (a) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        #1;
    endtask

    task automatic cycle(input logic r, input logic [NR-1:0] q, input logic [NR*DW-1:0] d,
                         input logic f);
        drive(r, q, d, f);
        sample();
        model_check();
        adv();
    endtask

    function automatic logic [NR*DW-1:0] pack_dat();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = dat[i];
        return v;
    endfunction

    task automatic clear_order();
        for (int i = 0; i < 8; i++) order[i] = -1;
        n_ord      = 0;
        prev_grant = '0;
    endtask

    // Continuous requests on mask q; records each new owner in order[]
    task automatic run_all(input logic [NR-1:0] q, input int n, output int pushes);
        pushes = 0;
        for (int c = 0; c < n; c++) begin
            cycle(1'b0, q, pack_dat(), 1'b0);
            if (s_push) pushes++;
            if (s_grant != 0 && s_grant != prev_grant && n_ord < 8) begin
                for (int i = 0; i < NR; i++) if (s_grant[i]) order[n_ord] = i;
                n_ord++;
            end
            prev_grant = s_grant;
            for (int i = 0; i < NR; i++) if (s_ack[i]) dat[i] = dat[i] + 8'd1;
        end
    endtask

    initial begin
        int            pushes;
        int            full_pushes;
        logic [NR-1:0] pend;
        logic          f;
        logic          r;
        int            exp_o [5];

        // Single producer, owner withdrawal, wrap-around from last_grant = 3
        tv[0]  = '{4'b0010, 32'h0000_1100, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tv[1]  = '{4'b0010, 32'h0000_1100, 1'b0, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1};
        tv[2]  = '{4'b0010, 32'h0000_2200, 1'b0, 4'b0010, 1'b1, 8'h22, 4'b0010, 1'b1};
        tv[3]  = '{4'b0010, 32'h0000_3300, 1'b0, 4'b0010, 1'b1, 8'h33, 4'b0010, 1'b1};
        tv[4]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b1};
        tv[5]  = '{4'b1000, 32'hA000_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tv[6]  = '{4'b1000, 32'hA000_0000, 1'b1, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b1};
        tv[7]  = '{4'b1000, 32'hA000_0000, 1'b0, 4'b1000, 1'b1, 8'hA0, 4'b1000, 1'b1};
        tv[8]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b1};
        tv[9]  = '{4'b1001, 32'hA100_0001, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tv[10] = '{4'b1001, 32'hA100_0001, 1'b0, 4'b0001, 1'b1, 8'h01, 4'b0001, 1'b1};
        tv[11] = '{4'b1000, 32'hA100_0000, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b1};
        tv[12] = '{4'b1000, 32'hA100_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tv[13] = '{4'b1000, 32'hA100_0000, 1'b0, 4'b1000, 1'b1, 8'hA1, 4'b1000, 1'b1};

        drive(1'b1, '0, '0, 1'b0);
        adv();
        cycle(1'b1, '0, '0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(1'b0, tv[i].q, tv[i].d, tv[i].f);
            sample();
            chk($sformatf("tv%0d_grant", i), 32'(s_grant), 32'(tv[i].e_grant));
            chk($sformatf("tv%0d_push", i), 32'(s_push), 32'(tv[i].e_push));
            chk($sformatf("tv%0d_ack", i), 32'(s_ack), 32'(tv[i].e_ack));
            chk($sformatf("tv%0d_busy", i), 32'(s_busy), 32'(tv[i].e_busy));
            if (tv[i].e_push) chk($sformatf("tv%0d_data", i), 32'(s_data), 32'(tv[i].e_data));
            adv();
        end

        // All four requesting: 16 words in 20 cycles, order 0,1,2,3,0
        cycle(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < NR; i++) dat[i] = 8'(i * 16);
        clear_order();
        run_all(4'b1111, 20, pushes);
        chk("t2_words_in_20", 32'(pushes), 32'd16);
        run_all(4'b1111, 2, pushes);
        exp_o = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(order[i]), 32'(exp_o[i]));

        // Full held 5 cycles mid-burst; count resumes where it stopped
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_1000, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_1000, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_1100, 1'b0);
        full_pushes = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 4'b0010, 32'h0000_5A00, 1'b1);
            if (s_push || s_ack != 0) full_pushes++;
            chk("t3_grant_held", 32'(s_grant), 32'h2);
        end
        chk("t3_no_push_full", 32'(full_pushes), 32'd0);
        cycle(1'b0, 4'b0010, 32'h0000_5A00, 1'b0);
        chk("t3_resume_push", 32'(s_push), 32'd1);
        chk("t3_resume_data", 32'(s_data), 32'h5A);
        cycle(1'b0, 4'b0010, 32'h0000_5B00, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_5C00, 1'b0);
        chk("t3_burst_end_busy", 32'(s_busy), 32'd0);

        // Owner 2 withdraws after 2 words; 3 then 0 served before 2 again
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b0, 4'b0100, 32'h0020_0000, 1'b0);
        cycle(1'b0, 4'b1101, 32'h3020_0000, 1'b0);
        cycle(1'b0, 4'b1101, 32'h3021_0000, 1'b0);
        cycle(1'b0, 4'b1001, 32'h3000_0000, 1'b0);
        chk("t4_withdraw_ack", 32'(s_ack), 32'd0);
        for (int i = 0; i < NR; i++) dat[i] = 8'(i * 16 + 8);
        clear_order();
        run_all(4'b1101, 12, pushes);
        chk("t4_first", 32'(order[0]), 32'd3);
        chk("t4_second", 32'(order[1]), 32'd0);
        chk("t4_third", 32'(order[2]), 32'd2);

        // Reset during second word of a burst from producer 1
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_4000, 1'b0);
        cycle(1'b0, 4'b0010, 32'h0000_4000, 1'b0);
        cycle(1'b1, 4'b0010, 32'h0000_4100, 1'b0);
        chk("t5_push_in_rst", 32'(s_push), 32'd0);
        cycle(1'b0, 4'b0011, 32'h0000_4101, 1'b0);
        chk("t5_grant", 32'(s_grant), 32'd0);
        chk("t5_busy", 32'(s_busy), 32'd0);
        chk("t5_push", 32'(s_push), 32'd0);
        cycle(1'b0, 4'b0011, 32'h0000_4101, 1'b0);
        chk("t5_next_grant", 32'(s_grant), 32'h1);

        // Randomized producers obeying the handshake, random full and reset
        cycle(1'b1, '0, '0, 1'b0);
        pend = '0;
        for (int i = 0; i < NR; i++) dat[i] = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            cycle(r, pend, pack_dat(), f);
            for (int i = 0; i < NR; i++) begin
                if (s_ack[i]) begin
                    if ($urandom_range(0, 9) < 7) dat[i] = 8'($urandom);
                    else pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
- Each producer raises a request and holds its data word. The arbiter grants one owner at a time and streams up to MAX_BURST words from that owner into the FIFO's push/data_in inputs, gated by the FIFO full flag.
- It then rotates priority to the next requester.
- It sits directly in front of the team FIFO. Its FIFO-side outputs connect straight to the FIFO's push, data_in and full ports.

Parameters:
- DATA_WIDTH, 8, width of each producer data word and of the FIFO data port.
- NUM_REQ, 4, number of producers (2..16).
- MAX_BURST, 4, maximum words accepted from one owner per grant (1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-high (asserted = 1), despite the name.
- req  input  NUM_REQ  per-producer request; bit i high = producer i has a valid word on its data slice.
- req_data  input  NUM_REQ*DATA_WIDTH  packed producer data; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-hot; bit i high = producer i's word is taken this cycle.
- grant  output  NUM_REQ  registered one-hot current owner; all-zero when no owner.
- fifo_full  input  1  FIFO full flag.
- fifo_push  output  1  FIFO push strobe.
- fifo_data  output  DATA_WIDTH  word presented to the FIFO data_in.
- busy  output  1  high while in state SERVE.

Behaviour:
- Reset (rst_n = 1 at a clock edge):
  - state = IDLE, grant = 0, burst_cnt = 0.
  - last_grant = NUM_REQ-1, so producer 0 has first priority.
  - ack = 0, fifo_push = 0, busy = 0 combinationally after the reset edge.
  - Reset has priority over all other activity. Reset mid-burst drops ownership immediately. A word presented in the same cycle as reset is not accepted.
- State IDLE:
  - If req != 0, select the winner by a circular search starting at last_grant+1 and wrapping modulo NUM_REQ.
  - Register the winner into grant, clear burst_cnt, go to SERVE.
  - No word is accepted in IDLE, giving a one-cycle arbitration bubble per grant.
- State SERVE, with owner o = index of grant:
  - accept = req[o] && !fifo_full (combinational).
  - fifo_push = accept; fifo_data = req_data slice o; ack = grant when accept, else 0.
  - fifo_data is a don't-care when fifo_push = 0, but it must still be driven from slice o (no X).
  - On accept: burst_cnt <= burst_cnt + 1.
  - Leave SERVE to IDLE, set last_grant <= o and clear grant, when either:
    - accept and burst_cnt == MAX_BURST-1 (burst exhausted), or
    - req[o] == 0 (owner withdrew; nothing accepted that cycle).
  - fifo_full with req[o] = 1: remain in SERVE indefinitely, no accept, burst_cnt held, no timeout.
- Producer handshake:
  - A producer holds req and its data stable until it sees ack.
  - After ack it may present a new word with req still high (back-to-back, one word per cycle) or drop req.
  - A producer may raise req at any time. It may drop req only when no word is pending.
- Only the owner's ack bit can ever be set. Non-owner requests wait, unaffected.
- Fairness: after an owner leaves, every other requester with req high is served before that owner is granted again.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles under continuous requests and a non-full FIFO.
- burst_cnt width is 8 bits; it never exceeds MAX_BURST-1.

Test Plan:
1. Reset then single producer: req = 4'b0010, data 0x11, 0x22, 0x33 on successive acks, then req drops. Expect grant = 4'b0010 one cycle after req, fifo_push high for 3 consecutive cycles with fifo_data 0x11, 0x22, 0x33, then IDLE with last_grant = 1.
2. All four requesting continuously, MAX_BURST = 4, FIFO never full. Expect grant order 0, 1, 2, 3, 0. Each grant yields exactly 4 acks followed by a one-cycle idle bubble, giving 16 words in 20 cycles.
3. fifo_full forced high for 5 cycles mid-burst while the owner holds 0x5A. Expect fifo_push = 0 and ack = 0 for those 5 cycles with grant unchanged. 0x5A is pushed in the cycle full drops, and the burst count continues from where it stopped.
4. Owner 2 drops req after 2 words while req[3] and req[0] are high. Expect return to IDLE, next grant = 3, then 0. Producer 2 is not granted again until 3 and 0 have been served.
5. rst_n asserted during cycle 2 of a 4-word burst from producer 1. Expect grant = 0, busy = 0 and no fifo_push after that edge. The next grant goes to producer 0 if it requests.
6. NUM_REQ = 4, req = 4'b1001 with last_grant = 3. Expect grant = 4'b0001 (wrap-around), then producer 3 after producer 0's burst.
